// File: rtl/ysyx_24110015_csr_pkg.sv
// Shared encodings for the machine-mode CSR sequencer: op codes, CSR map,
// FSM states and mstatus field positions.
package ysyx_24110015_csr_pkg;

    localparam logic [2:0] OP_CSRRW = 3'd0;
    localparam logic [2:0] OP_CSRRS = 3'd1;
    localparam logic [2:0] OP_CSRRC = 3'd2;
    localparam logic [2:0] OP_ECALL = 3'd3;
    localparam logic [2:0] OP_MRET  = 3'd4;

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MVENDORID = 12'hF11;
    localparam logic [11:0] ADDR_MARCHID   = 12'hF12;

    localparam int unsigned MSTATUS_MIE    = 3;
    localparam int unsigned MSTATUS_MPIE   = 7;
    localparam int unsigned MSTATUS_MPP_LO = 11;
    localparam int unsigned MSTATUS_MPP_HI = 12;

    localparam logic [31:0] ECALL_CAUSE_M = 32'd11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_TRAP_EPC,
        S_TRAP_STS,
        S_RET_STS,
        S_RESP
    } state_t;

    function automatic logic is_ro(input logic [11:0] addr);
        return (addr == ADDR_MVENDORID) || (addr == ADDR_MARCHID);
    endfunction

    function automatic logic [31:0] mstatus_trap(input logic [31:0] s);
        logic [31:0] r;
        r = s;
        r[MSTATUS_MPIE] = s[MSTATUS_MIE];
        r[MSTATUS_MIE]  = 1'b0;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

    function automatic logic [31:0] mstatus_ret(input logic [31:0] s);
        logic [31:0] r;
        r = s;
        r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

endpackage

// File: rtl/ysyx_24110015_csr_alu.sv
// Combinational CSRRW/CSRRS/CSRRC evaluator: computes the new value, whether
// the CSR is written, and whether the access is illegal.
module ysyx_24110015_csr_alu
    import ysyx_24110015_csr_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      op,
    input  logic [11:0]     addr,
    input  logic [XLEN-1:0] wdata,
    input  logic            src_zero,
    input  logic [XLEN-1:0] old,
    output logic [XLEN-1:0] new_val,
    output logic            wen,
    output logic            illegal
);

    logic op_ok;
    logic addr_ok;
    logic writes;

    always_comb begin
        op_ok   = (op == OP_CSRRW) || (op == OP_CSRRS) || (op == OP_CSRRC);
        addr_ok = (addr == ADDR_MSTATUS) || (addr == ADDR_MTVEC) ||
                  (addr == ADDR_MEPC) || (addr == ADDR_MCAUSE) || is_ro(addr);
        // CSRRS/CSRRC with a zero source never write, so they may read RO CSRs
        writes  = (op == OP_CSRRW) || !src_zero;
        illegal = !op_ok || !addr_ok || (is_ro(addr) && writes);
        wen     = !illegal && writes;

        case (op)
            OP_CSRRS: new_val = old | wdata;
            OP_CSRRC: new_val = old & ~wdata;
            default:  new_val = wdata;
        endcase
    end

endmodule

// File: rtl/ysyx_24110015_csr_ctrl.sv
// Request sequencer for the machine-mode CSR file: accepts one EXU request,
// drives the CSR write ports in the right cycles and returns a response.
module ysyx_24110015_csr_ctrl
    import ysyx_24110015_csr_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] ECALL_CAUSE = 32'd11
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [11:0]     req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic            req_src_zero,
    input  logic [XLEN-1:0] req_pc,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_redirect,
    output logic [XLEN-1:0] resp_target,
    output logic            resp_illegal,
    input  logic [XLEN-1:0] dout_mstatus,
    input  logic [XLEN-1:0] dout_mtvec,
    input  logic [XLEN-1:0] dout_mepc,
    input  logic [XLEN-1:0] dout_mcause,
    input  logic [XLEN-1:0] dout_mvendorid,
    input  logic [XLEN-1:0] dout_marchid,
    output logic [XLEN-1:0] din_mstatus,
    output logic [XLEN-1:0] din_mtvec,
    output logic [XLEN-1:0] din_mepc,
    output logic [XLEN-1:0] din_mcause,
    output logic            wen_mstatus,
    output logic            wen_mtvec,
    output logic            wen_mepc,
    output logic            wen_mcause
);

    state_t          state;
    state_t          next;
    logic [2:0]      op_q;
    logic [11:0]     addr_q;
    logic [XLEN-1:0] wdata_q;
    logic            src_zero_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] old;
    logic [XLEN-1:0] alu_new;
    logic            alu_wen;
    logic            alu_illegal;

    always_comb begin
        case (addr_q)
            ADDR_MSTATUS:   old = dout_mstatus;
            ADDR_MTVEC:     old = dout_mtvec;
            ADDR_MEPC:      old = dout_mepc;
            ADDR_MCAUSE:    old = dout_mcause;
            ADDR_MVENDORID: old = dout_mvendorid;
            ADDR_MARCHID:   old = dout_marchid;
            default:        old = '0;
        endcase
    end

    ysyx_24110015_csr_alu #(
        .XLEN(XLEN)
    ) u_alu (
        .op      (op_q),
        .addr    (addr_q),
        .wdata   (wdata_q),
        .src_zero(src_zero_q),
        .old     (old),
        .new_val (alu_new),
        .wen     (alu_wen),
        .illegal (alu_illegal)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= next;
    end

    // Write ports are decoded from the current state so an async reset drops them at once
    always_comb begin
        next        = state;
        req_ready   = 1'b0;
        wen_mstatus = 1'b0;
        wen_mtvec   = 1'b0;
        wen_mepc    = 1'b0;
        wen_mcause  = 1'b0;
        din_mstatus = '0;
        din_mtvec   = '0;
        din_mepc    = '0;
        din_mcause  = '0;

        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    case (req_op)
                        OP_ECALL: next = S_TRAP_EPC;
                        OP_MRET:  next = S_RET_STS;
                        default:  next = S_EXEC;
                    endcase
                end
            end
            S_EXEC: begin
                next = S_RESP;
                if (alu_wen) begin
                    case (addr_q)
                        ADDR_MSTATUS: begin wen_mstatus = 1'b1; din_mstatus = alu_new; end
                        ADDR_MTVEC:   begin wen_mtvec   = 1'b1; din_mtvec   = alu_new; end
                        ADDR_MEPC:    begin wen_mepc    = 1'b1; din_mepc    = alu_new; end
                        ADDR_MCAUSE:  begin wen_mcause  = 1'b1; din_mcause  = alu_new; end
                        default: ;
                    endcase
                end
            end
            S_TRAP_EPC: begin
                next       = S_TRAP_STS;
                wen_mepc   = 1'b1;
                din_mepc   = pc_q;
                wen_mcause = 1'b1;
                din_mcause = ECALL_CAUSE;
            end
            S_TRAP_STS: begin
                next        = S_RESP;
                wen_mstatus = 1'b1;
                din_mstatus = mstatus_trap(dout_mstatus);
            end
            S_RET_STS: begin
                next        = S_RESP;
                wen_mstatus = 1'b1;
                din_mstatus = mstatus_ret(dout_mstatus);
            end
            S_RESP: begin
                if (resp_ready) next = S_IDLE;
            end
            default: next = S_IDLE;
        endcase
    end

    assign resp_valid = (state == S_RESP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q          <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            src_zero_q    <= 1'b0;
            pc_q          <= '0;
            resp_rdata    <= '0;
            resp_target   <= '0;
            resp_redirect <= 1'b0;
            resp_illegal  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        op_q          <= req_op;
                        addr_q        <= req_addr;
                        wdata_q       <= req_wdata;
                        src_zero_q    <= req_src_zero;
                        pc_q          <= req_pc;
                        resp_rdata    <= '0;
                        resp_target   <= '0;
                        resp_redirect <= 1'b0;
                        resp_illegal  <= 1'b0;
                    end
                end
                S_EXEC: begin
                    resp_rdata   <= alu_illegal ? '0 : old;
                    resp_illegal <= alu_illegal;
                end
                S_TRAP_STS: begin
                    resp_redirect <= 1'b1;
                    resp_target   <= {dout_mtvec[XLEN-1:2], 2'b00};
                end
                S_RET_STS: begin
                    resp_redirect <= 1'b1;
                    resp_target   <= dout_mepc;
                end
                default: ;
            endcase
        end
    end

endmodule
